// File: rtl/systolic_output_postproc_if.sv
// Handshake bundle between the systolic output post-processor and its neighbours:
// tile command, accumulator rows in, post-processed rows out, tile response.
interface systolic_output_postproc_if #(
    parameter int DIM = 8,
    parameter int W   = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_relu_en;
    logic [DIM*W-1:0]   cmd_bias;
    logic               in_valid;
    logic               in_ready;
    logic [DIM*W-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [DIM*W-1:0]   out_data;
    logic               out_last;
    logic               resp_valid;
    logic               resp_ready;

    modport slave (
        input  cmd_valid, cmd_relu_en, cmd_bias, in_valid, in_data, out_ready, resp_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last, resp_valid
    );

    modport master (
        output cmd_valid, cmd_relu_en, cmd_bias, in_valid, in_data, out_ready, resp_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, resp_valid
    );
endinterface

// File: rtl/systolic_output_postproc.sv
// Per-lane bias add, saturation and optional ReLU on accumulator rows, one DIM x DIM tile per command.
// Two-stage pipeline (add, then clamp) with a shared stall enable and a command/response FSM.
module systolic_output_postproc #(
    parameter int SYSTOLIC_ARRAY_DIM = 8,
    parameter int DATA_WIDTH_BITS    = 16,
    parameter int INT_BITS           = 8,
    parameter int FRAC_BITS          = 8
) (
    input  logic                       clock,
    input  logic                       areset,
    systolic_output_postproc_if.slave  bus
);
    localparam int DIM = SYSTOLIC_ARRAY_DIM;
    localparam int W   = DATA_WIDTH_BITS;
    localparam int L   = DIM * W;
    localparam int SW  = W + 1;
    localparam int CW  = $clog2(DIM + 1);
    localparam logic [CW-1:0] DIM_C  = CW'(DIM);
    localparam logic [CW-1:0] LAST_C = CW'(DIM - 1);

    generate
        if (INT_BITS + FRAC_BITS != DATA_WIDTH_BITS) begin : g_fmt_check
            $error("INT_BITS + FRAC_BITS must equal DATA_WIDTH_BITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic [L-1:0]     bias_q, bias_d;
    logic             relu_q, relu_d;
    logic             s1_valid_q, s1_valid_d;
    logic [DIM*SW-1:0] s1_sum_q, s1_sum_d;
    logic             s1_last_q, s1_last_d;
    logic             s2_valid_q, s2_valid_d;
    logic [L-1:0]     s2_data_q, s2_data_d;
    logic             s2_last_q, s2_last_d;

    logic             en;
    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic [DIM*SW-1:0] sum_all;
    logic [L-1:0]     post_all;

    assign en       = !s2_valid_q || bus.out_ready;
    assign in_ready = (state_q == RUN) && (in_cnt_q < DIM_C) && en;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = s2_valid_q && bus.out_ready;

    // Lane datapath: sum is one bit wider than a lane so the clamp can see overflow.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            logic [SW-1:0] lane_sum;
            logic [SW-1:0] lane_s1;
            logic [W-1:0]  lane_sat;

            assign lane_sum = {bus.in_data[gi*W + W - 1], bus.in_data[gi*W +: W]}
                            + {bias_q[gi*W + W - 1], bias_q[gi*W +: W]};
            assign sum_all[gi*SW +: SW] = lane_sum;

            assign lane_s1  = s1_sum_q[gi*SW +: SW];
            assign lane_sat = (lane_s1[W] != lane_s1[W-1])
                            ? (lane_s1[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                            : lane_s1[W-1:0];
            assign post_all[gi*W +: W] = (relu_q && lane_sat[W-1]) ? '0 : lane_sat;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        bias_d     = bias_q;
        relu_d     = relu_q;
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;

        if (in_fire) begin
            in_cnt_d = in_cnt_q + 1'b1;
        end
        if (out_fire && (out_cnt_q != DIM_C)) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = RUN;
                    bias_d    = bus.cmd_bias;
                    relu_d    = bus.cmd_relu_en;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if (out_fire && s2_last_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Both stages move together so a stalled output row is never overwritten.
        if (en) begin
            s1_valid_d = in_fire;
            s1_sum_d   = sum_all;
            s1_last_d  = (in_cnt_q == LAST_C);
            s2_valid_d = s1_valid_q;
            s2_data_d  = post_all;
            s2_last_d  = s1_valid_q && s1_last_q;
        end
    end

    always_ff @(posedge clock or negedge areset) begin
        if (!areset) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            bias_q     <= '0;
            relu_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            bias_q     <= bias_d;
            relu_q     <= relu_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_data   = s2_data_q;
    assign bus.out_last   = s2_last_q;
    assign bus.resp_valid = (state_q == RESP);
endmodule
